// File: rtl/snn_rate_decoder_pkg.sv
`default_nettype none
// ============================================================================
// snn_rate_decoder_pkg : shared defaults, FSM encoding and helpers
// Revision 1.0
// ============================================================================
package snn_rate_decoder_pkg;

  localparam int c_default_neurons    = 8;
  localparam int c_default_count_bits = 8;

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // A window length of 0 encodes 256 steps.
  function automatic logic [8:0] f_window_len(input logic [7:0] len);
    return (len == 8'd0) ? 9'd256 : {1'b0, len};
  endfunction

endpackage
`default_nettype wire

// File: rtl/snn_rate_decoder_spike_counter.sv
`default_nettype none
// ============================================================================
// spike_counter : per-neuron saturating spike counter
// Revision 1.0
// ============================================================================
module spike_counter
  import snn_rate_decoder_pkg::*;
#(
  parameter int COUNT_BITS = c_default_count_bits
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_clr,
  input  logic                  i_inc,
  output logic [COUNT_BITS-1:0] o_count
);

  logic [COUNT_BITS-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst_n || i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + COUNT_BITS'(1);
    end
  end

  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/snn_rate_decoder.sv
`default_nettype none
// ============================================================================
// snn_rate_decoder : counts output-layer spikes over a window, reports argmax
// Revision 1.0
// ============================================================================
module snn_rate_decoder
  import snn_rate_decoder_pkg::*;
#(
  parameter int NEURONS    = c_default_neurons,
  parameter int COUNT_BITS = c_default_count_bits,
  localparam int IDX_W     = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NEURONS-1:0]    spikes,
  input  logic                  spike_valid,
  input  logic [7:0]            window_len,
  input  logic                  clear,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [IDX_W-1:0]      class_idx,
  output logic [COUNT_BITS-1:0] class_count,
  output logic                  busy,
  output logic                  dropped
);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [8:0]            r_step;
  logic [8:0]            r_len;
  logic [IDX_W-1:0]      r_scan_idx;
  logic [IDX_W-1:0]      r_best_idx;
  logic [COUNT_BITS-1:0] r_best_cnt;
  logic                  r_dropped;
  logic [COUNT_BITS-1:0] w_counts [NEURONS];

  logic       w_accept;
  logic [8:0] w_len_now;
  logic [8:0] w_len_eff;
  logic       w_last_step;
  logic       w_scan_last;
  logic       w_handshake;
  logic       w_cnt_clr;

  assign w_accept    = (r_state == ST_ACCUM) && spike_valid && !clear;
  assign w_len_now   = f_window_len(window_len);
  // The first step of a window uses the live length; later steps the latched one.
  assign w_len_eff   = (r_step == 9'd0) ? w_len_now : r_len;
  assign w_last_step = w_accept && ((r_step + 9'd1) == w_len_eff);
  assign w_scan_last = (r_state == ST_SCAN) && (r_scan_idx == IDX_W'(NEURONS - 1));
  assign w_handshake = (r_state == ST_DONE) && result_ready;
  assign w_cnt_clr   = clear || w_handshake;

  generate
    for (genvar gi = 0; gi < NEURONS; gi++) begin : g_counter
      spike_counter #(
        .COUNT_BITS (COUNT_BITS)
      ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_cnt_clr),
        .i_inc   (w_accept && spikes[gi]),
        .o_count (w_counts[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = ST_ACCUM;
    end else begin
      case (r_state)
        ST_ACCUM: if (w_last_step) w_state_nxt = ST_SCAN;
        ST_SCAN:  if (w_scan_last) w_state_nxt = ST_DONE;
        ST_DONE:  if (w_handshake) w_state_nxt = ST_ACCUM;
        default:  w_state_nxt = ST_ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_step     <= '0;
      r_len      <= '0;
      r_scan_idx <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
      r_dropped  <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_step <= '0;
        r_len  <= '0;
      end else if (w_accept) begin
        r_step <= r_step + 9'd1;
        if (r_step == 9'd0) r_len <= w_len_now;
      end

      // Strictly-greater replacement keeps the lowest index on ties.
      if (r_state == ST_SCAN) begin
        r_scan_idx <= r_scan_idx + IDX_W'(1);
        if (w_counts[r_scan_idx] > r_best_cnt) begin
          r_best_idx <= r_scan_idx;
          r_best_cnt <= w_counts[r_scan_idx];
        end
      end else begin
        r_scan_idx <= '0;
        if (r_state == ST_ACCUM) begin
          r_best_idx <= '0;
          r_best_cnt <= '0;
        end
      end

      if (clear) begin
        r_dropped <= 1'b0;
      end else if (spike_valid && (r_state != ST_ACCUM)) begin
        r_dropped <= 1'b1;
      end
    end
  end

  assign result_valid = (r_state == ST_DONE);
  assign busy         = (r_state != ST_ACCUM);
  assign class_idx    = result_valid ? r_best_idx : '0;
  assign class_count  = result_valid ? r_best_cnt : '0;
  assign dropped      = r_dropped;

endmodule
`default_nettype wire

// File: doc/snn_rate_decoder.md
SNN_RATE_DECODER -- requirements
Module: snn_rate_decoder

Interface
REQ-001 SHALL have parameter NEURONS, default 8: number of output-layer spike lines decoded.
REQ-002 SHALL have parameter COUNT_BITS, default 8: width of each per-neuron spike counter.
REQ-003 SHALL have port clk, input, 1: the single clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port spikes, input, NEURONS: output spikes of the last network layer, bit i = neuron i.
REQ-006 SHALL have port spike_valid, input, 1: spikes hold one valid network time step this cycle.
REQ-007 SHALL have port window_len, input, 8: time steps per decision window; 0 means 256.
REQ-008 SHALL have port clear, input, 1: abort the current window and zero all counters.
REQ-009 SHALL have port result_valid, output, 1: class_idx/class_count hold a decision.
REQ-010 SHALL have port result_ready, input, 1: consumer accepts the decision.
REQ-011 SHALL have port class_idx, output, clog2(NEURONS): index of the winning neuron.
REQ-012 SHALL have port class_count, output, COUNT_BITS: spike count of the winner.
REQ-013 SHALL have port busy, output, 1: high in SCAN and DONE states.
REQ-014 SHALL have port dropped, output, 1: sticky flag, a spike_valid step arrived while not in ACCUM.

Function
REQ-015 SHALL implement the FSM states ACCUM, SCAN and DONE.
REQ-016 ACCUM: each spike_valid cycle SHALL increment counter i for every set spikes[i] and increment step_count.
REQ-017 Counters SHALL saturate at 2^COUNT_BITS-1 and never wrap.
REQ-018 window_len SHALL be latched on the first accepted step of a window; later changes apply only to the next window.
REQ-019 When the accepted step makes step_count equal the latched length (cycle T), the FSM SHALL enter SCAN at T+1 and that step's spikes SHALL be counted.
REQ-020 SCAN: one counter SHALL be compared per cycle, index 0 first, for NEURONS cycles (T+1..T+NEURONS).
REQ-021 The argmax SHALL replace the held winner only on a strictly greater count, so ties resolve to the lowest index.
REQ-022 All-zero counts SHALL yield class_idx=0, class_count=0.
REQ-023 result_valid SHALL rise at T+NEURONS+1 (DONE) and hold, with stable class_idx/class_count, until result_valid&&result_ready at an edge.
REQ-024 On handshake, counters and step_count SHALL clear and the FSM SHALL return to ACCUM next cycle; result_valid drops the same cycle.
REQ-025 spike_valid in SCAN or DONE SHALL be ignored and SHALL set dropped; dropped clears only on reset or clear.
REQ-026 clear SHALL force ACCUM and zero counters, step_count, result_valid and dropped next cycle; it overrides spike_valid and the handshake.
REQ-027 class_idx/class_count SHALL be 0 outside DONE.

Reset
REQ-028 While rst_n=0 at an edge: state=ACCUM, counters=0, step_count=0, latched length=0, result_valid=0, class_idx=0, class_count=0, busy=0, dropped=0.
REQ-029 Reset mid-SCAN or mid-DONE SHALL discard the decision with no result_valid pulse.

Structure
REQ-030 FSM state encodings and the default NEURONS/COUNT_BITS SHALL live in the shared snn package/header.
REQ-031 A per-neuron saturating counter SHALL be one sub-module, spike_counter, instantiated NEURONS times.

Verification
REQ-032 window_len=4, spikes 8'h01 for 4 steps -> at T+9 result_valid=1, class_idx=0, class_count=4.
REQ-033 window_len=3, neurons 2 and 5 each spike 3 times -> class_idx=2, class_count=3 (tie, lowest index).
REQ-034 COUNT_BITS=4, window_len=20, spikes 8'h80 every step -> class_idx=7, class_count=15 (saturated).
REQ-035 result_ready held low for 10 cycles in DONE with spike_valid pulses -> outputs stable, dropped=1; ready=1 -> ACCUM, counters 0.
REQ-036 clear (or rst_n=0) asserted at the 2nd SCAN cycle -> no result_valid; next window of 2 steps of 8'h08 -> class_idx=3, count=2.
